// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - opcode/funct constants, ALU op and FSM encodings, control decode
package decode_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Shared with the ALU stage; keep the numeric values stable.
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    DEST_NONE = 2'd0,
    DEST_RD   = 2'd1,
    DEST_RT   = 2'd2
  } dest_sel_e;

  typedef struct packed {
    alu_op_e   alu_op;
    dest_sel_e dest_sel;
    logic      reg_write;
    logic      mem_read;
    logic      mem_write;
    logic      branch;
    logic      jump;
    logic      illegal;
  } ctrl_t;

  // Unsupported opcodes/functs leave every side-effect enable low so the
  // token can still flow downstream harmlessly.
  function automatic ctrl_t decode_ctrl(input logic [31:0] instr);
    ctrl_t c;
    c = '0;
    case (instr[31:26])
      OP_RTYPE: begin
        c.reg_write = 1'b1;
        c.dest_sel  = DEST_RD;
        case (instr[5:0])
          FN_ADD:  c.alu_op = ALU_ADD;
          FN_SUB:  c.alu_op = ALU_SUB;
          FN_AND:  c.alu_op = ALU_AND;
          FN_OR:   c.alu_op = ALU_OR;
          FN_SLT:  c.alu_op = ALU_SLT;
          default: begin
            c.illegal   = 1'b1;
            c.reg_write = 1'b0;
            c.dest_sel  = DEST_NONE;
          end
        endcase
      end
      OP_ADDI: begin
        c.reg_write = 1'b1;
        c.dest_sel  = DEST_RT;
      end
      OP_LW: begin
        c.mem_read  = 1'b1;
        c.reg_write = 1'b1;
        c.dest_sel  = DEST_RT;
      end
      OP_SW:   c.mem_write = 1'b1;
      OP_BEQ: begin
        c.alu_op = ALU_SUB;
        c.branch = 1'b1;
      end
      OP_J:    c.jump = 1'b1;
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// rtl/decode_stage_reg_file.sv - 2R/1W register file, r0 hardwired zero, write-through bypass under FORWARD_WB_EN
module decode_stage_reg_file #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_wr_en,
  input  logic [REG_AW-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [REG_AW-1:0] i_rd_addr_a,
  output logic [DATA_W-1:0] o_rd_data_a,
  input  logic [REG_AW-1:0] i_rd_addr_b,
  output logic [DATA_W-1:0] o_rd_data_b
);

  localparam int NUM_REGS = 1 << REG_AW;

  logic [DATA_W-1:0] r_mem [NUM_REGS];

  // Synchronous clear; writes to r0 are dropped so it never holds a value.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en && (i_wr_addr != '0)) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Asynchronous reads; r0 forced to zero, optional same-cycle bypass.
  always_comb begin
    o_rd_data_a = (i_rd_addr_a == '0) ? '0 : r_mem[i_rd_addr_a];
    o_rd_data_b = (i_rd_addr_b == '0) ? '0 : r_mem[i_rd_addr_b];
`ifdef FORWARD_WB_EN
    if (i_wr_en && (i_wr_addr != '0) && (i_wr_addr == i_rd_addr_a)) begin
      o_rd_data_a = i_wr_data;
    end
    if (i_wr_en && (i_wr_addr != '0) && (i_wr_addr == i_rd_addr_b)) begin
      o_rd_data_b = i_wr_data;
    end
`endif
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - decode/register-read stage (IDLE->DECODE->HOLD handshake), bypass under FORWARD_WB_EN
module decode_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              stage_in,
  input  logic [31:0]       instr_in,
  output logic              in_ready,
  output logic              stage_out,
  input  logic              alu_ready,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] imm_ext,
  output logic [REG_AW-1:0] dest_reg,
  output logic [2:0]        alu_op,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              branch,
  output logic              jump,
  output logic              illegal,
  output logic              err_ovr
);

  import decode_stage_pkg::*;

  state_e            r_state;
  state_e            w_state_nxt;
  logic              w_load_ir;
  logic              w_load_out;
  logic [31:0]       r_ir;
  ctrl_t             w_ctrl;
  logic [REG_AW-1:0] w_rs_addr;
  logic [REG_AW-1:0] w_rt_addr;
  logic [REG_AW-1:0] w_dest;
  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;

  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm_ext;
  logic [REG_AW-1:0] r_dest_reg;
  alu_op_e           r_alu_op;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_branch;
  logic              r_jump;
  logic              r_illegal;
  logic              r_err_ovr;

  assign w_rs_addr = REG_AW'(r_ir[25:21]);
  assign w_rt_addr = REG_AW'(r_ir[20:16]);
  assign w_ctrl    = decode_ctrl(r_ir);

  decode_stage_reg_file #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_reg_file (
    .i_clock     (clock),
    .i_reset_n   (reset_n),
    .i_wr_en     (wb_en),
    .i_wr_addr   (wb_addr),
    .i_wr_data   (wb_data),
    .i_rd_addr_a (w_rs_addr),
    .o_rd_data_a (w_rs_val),
    .i_rd_addr_b (w_rt_addr),
    .o_rd_data_b (w_rt_val)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and load strobes: accept in IDLE, capture outputs in DECODE, wait for ALU in HOLD.
  always_comb begin
    w_state_nxt = r_state;
    w_load_ir   = 1'b0;
    w_load_out  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (stage_in) begin
          w_load_ir   = 1'b1;
          w_state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        w_load_out  = 1'b1;
        w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (alu_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Destination register selection from decoded control.
  always_comb begin
    w_dest = '0;
    case (w_ctrl.dest_sel)
      DEST_RD: w_dest = REG_AW'(r_ir[15:11]);
      DEST_RT: w_dest = REG_AW'(r_ir[20:16]);
      default: w_dest = '0;
    endcase
  end

  // Instruction register, loaded only when a token is accepted.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_ir <= '0;
    end else if (w_load_ir) begin
      r_ir <= instr_in;
    end
  end

  // Output registers captured in DECODE and frozen through HOLD.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm_ext   <= '0;
      r_dest_reg  <= '0;
      r_alu_op    <= ALU_ADD;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_branch    <= 1'b0;
      r_jump      <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_load_out) begin
      r_rs_data   <= w_rs_val;
      r_rt_data   <= w_rt_val;
      r_imm_ext   <= {{(DATA_W-16){r_ir[15]}}, r_ir[15:0]};
      r_dest_reg  <= w_dest;
      r_alu_op    <= w_ctrl.alu_op;
      r_reg_write <= w_ctrl.reg_write;
      r_mem_read  <= w_ctrl.mem_read;
      r_mem_write <= w_ctrl.mem_write;
      r_branch    <= w_ctrl.branch;
      r_jump      <= w_ctrl.jump;
      r_illegal   <= w_ctrl.illegal;
    end
  end

  // Sticky overrun flag: a token offered while busy is dropped and flagged.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_err_ovr <= 1'b0;
    end else if (stage_in && !in_ready) begin
      r_err_ovr <= 1'b1;
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign stage_out = (r_state == ST_HOLD);
  assign rs_data   = r_rs_data;
  assign rt_data   = r_rt_data;
  assign imm_ext   = r_imm_ext;
  assign dest_reg  = r_dest_reg;
  assign alu_op    = r_alu_op;
  assign reg_write = r_reg_write;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign branch    = r_branch;
  assign jump      = r_jump;
  assign illegal   = r_illegal;
  assign err_ovr   = r_err_ovr;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized self-checking bench for decode_stage against a behavioural model
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        stage_in = 1'b0;
  logic [31:0] instr_in = '0;
  logic        in_ready;
  logic        stage_out;
  logic        alu_ready = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] imm_ext;
  logic [4:0]  dest_reg;
  logic [2:0]  alu_op;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        branch;
  logic        jump;
  logic        illegal;
  logic        err_ovr;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] model_regs [32];

  decode_stage dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .stage_in  (stage_in),
    .instr_in  (instr_in),
    .in_ready  (in_ready),
    .stage_out (stage_out),
    .alu_ready (alu_ready),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .imm_ext   (imm_ext),
    .dest_reg  (dest_reg),
    .alu_op    (alu_op),
    .reg_write (reg_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .branch    (branch),
    .jump      (jump),
    .illegal   (illegal),
    .err_ovr   (err_ovr)
  );

  always #5 clock = ~clock;

  wire [109:0] w_obs = {rs_data, rt_data, imm_ext, dest_reg, alu_op,
                        reg_write, mem_read, mem_write, branch, jump, illegal};

  // Expected output bundle for an instruction, from the ISA table and the model register array.
  function automatic logic [109:0] exp_out(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    logic [2:0] aop;
    logic [4:0] dst;
    logic rw, mr, mw, br, jp, il;
    op = ins[31:26];
    fn = ins[5:0];
    aop = 3'd0; dst = 5'd0;
    rw = 0; mr = 0; mw = 0; br = 0; jp = 0; il = 0;
    case (op)
      6'h00: begin
        case (fn)
          6'h20: aop = 3'd0;
          6'h22: aop = 3'd1;
          6'h24: aop = 3'd2;
          6'h25: aop = 3'd3;
          6'h2A: aop = 3'd4;
          default: il = 1;
        endcase
        if (!il) begin rw = 1; dst = ins[15:11]; end
      end
      6'h08: begin rw = 1; dst = ins[20:16]; end
      6'h23: begin mr = 1; rw = 1; dst = ins[20:16]; end
      6'h2B: mw = 1;
      6'h04: begin aop = 3'd1; br = 1; end
      6'h02: jp = 1;
      default: il = 1;
    endcase
    return {model_regs[ins[25:21]], model_regs[ins[20:16]],
            {{16{ins[15]}}, ins[15:0]}, dst, aop, rw, mr, mw, br, jp, il};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [5:0]  ops [7];
    logic [5:0]  fns [6];
    int k;
    ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h00};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
    w = $urandom;
    k = $urandom_range(0, 7);
    if (k < 7) w[31:26] = ops[k];
    if (w[31:26] == 6'h00) begin
      k = $urandom_range(0, 5);
      w[5:0] = (k < 5) ? fns[k] : 6'($urandom);
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model_regs[i] = '0;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
    if (a != 5'd0) model_regs[a] = d;
  endtask

  // Presents one token in IDLE and waits (bounded) for stage_out; lat = edges from acceptance.
  task automatic send(input logic [31:0] ins, output int lat);
    stage_in = 1'b1; instr_in = ins;
    tick();
    stage_in = 1'b0; instr_in = $urandom;
    lat = 1;
    while (stage_out !== 1'b1 && lat < 8) begin
      tick();
      lat++;
    end
  endtask

  task automatic accept();
    alu_ready = 1'b1;
    tick();
    alu_ready = 1'b0;
  endtask

  task automatic test_reset();
    wb_write(5'd8, 32'h1111_1111);
    wb_write(5'd9, 32'h2222_2222);
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    model_clear();
    n_checks++;
    if ({in_ready, stage_out, err_ovr} !== 3'b100)
      $display("FAIL reset_flags: got %b expected 100", {in_ready, stage_out, err_ovr});
    else n_pass++;
    n_checks++;
    if (w_obs !== '0) $display("FAIL reset_outputs: got %h expected 0", w_obs);
    else n_pass++;
    begin
      int lat;
      send(32'h0109_5020, lat);
      n_checks++;
      if ({rs_data, rt_data} !== 64'd0)
        $display("FAIL reset_regs_cleared: got %h expected 0", {rs_data, rt_data});
      else n_pass++;
      accept();
    end
  endtask

  task automatic test_add();
    int lat;
    wb_write(5'd8, 32'd5);
    wb_write(5'd9, 32'd7);
    send(32'h0109_5020, lat);
    n_checks++;
    if (lat !== 2) $display("FAIL add_latency: got %0d expected 2", lat);
    else n_pass++;
    n_checks++;
    if ({rs_data, rt_data, alu_op, dest_reg, reg_write} !== {32'd5, 32'd7, 3'd0, 5'd10, 1'b1})
      $display("FAIL add_fields: got rs=%h rt=%h op=%0d dst=%0d rw=%b expected 5 7 0 10 1",
               rs_data, rt_data, alu_op, dest_reg, reg_write);
    else n_pass++;
    accept();
    n_checks++;
    if ({stage_out, in_ready} !== 2'b01)
      $display("FAIL add_release: got %b expected 01", {stage_out, in_ready});
    else n_pass++;
  endtask

  task automatic test_lw_hold();
    int lat;
    logic [109:0] snap;
    send(32'h8D0B_FFFC, lat);
    n_checks++;
    if ({imm_ext, mem_read, dest_reg} !== {32'hFFFF_FFFC, 1'b1, 5'd11})
      $display("FAIL lw_fields: got imm=%h mr=%b dst=%0d expected FFFFFFFC 1 11",
               imm_ext, mem_read, dest_reg);
    else n_pass++;
    snap = exp_out(32'h8D0B_FFFC);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (w_obs !== snap || stage_out !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL lw_hold_stable: got %h so=%b ir=%b expected %h so=1 ir=0",
                 w_obs, stage_out, in_ready, snap);
      else n_pass++;
    end
    accept();
  endtask

  task automatic test_illegal_ovr();
    int lat;
    logic [31:0] ins;
    logic [109:0] exp;
    ins = {6'h3F, 26'($urandom)};
    exp = exp_out(ins);
    send(ins, lat);
    n_checks++;
    if ({illegal, reg_write, mem_read, mem_write, branch, jump} !== 6'b100000)
      $display("FAIL illegal_flags: got %b expected 100000",
               {illegal, reg_write, mem_read, mem_write, branch, jump});
    else n_pass++;
    stage_in = 1'b1; instr_in = 32'h0109_5020;
    tick();
    stage_in = 1'b0;
    n_checks++;
    if (err_ovr !== 1'b1 || w_obs !== exp)
      $display("FAIL ovr_set: got err=%b obs=%h expected err=1 obs=%h", err_ovr, w_obs, exp);
    else n_pass++;
    accept();
    send(32'h0109_5020, lat);
    accept();
    n_checks++;
    if (err_ovr !== 1'b1) $display("FAIL ovr_sticky: got %b expected 1", err_ovr);
    else n_pass++;
  endtask

  task automatic test_forward();
    int lat;
    logic [31:0] exp_rs;
    wb_write(5'd8, 32'h0000_1234);
`ifdef FORWARD_WB_EN
    exp_rs = 32'h55;
`else
    exp_rs = 32'h0000_1234;
`endif
    stage_in = 1'b1; instr_in = 32'h0109_5020;
    tick();
    stage_in = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h55;
    tick();
    wb_en = 1'b0;
    model_regs[8] = 32'h55;
    n_checks++;
    if (stage_out !== 1'b1 || rs_data !== exp_rs)
      $display("FAIL fwd_decode_cycle: got so=%b rs=%h expected so=1 rs=%h", stage_out, rs_data, exp_rs);
    else n_pass++;
    accept();
    send(32'h0109_5020, lat);
    n_checks++;
    if (rs_data !== 32'h55) $display("FAIL fwd_next_read: got %h expected 55", rs_data);
    else n_pass++;
    accept();
    wb_write(5'd0, 32'hDEAD_BEEF);
    stage_in = 1'b1; instr_in = 32'h0000_5020;
    tick();
    stage_in = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hCAFE_F00D;
    tick();
    wb_en = 1'b0;
    n_checks++;
    if ({rs_data, rt_data} !== 64'd0)
      $display("FAIL r0_zero: got %h expected 0", {rs_data, rt_data});
    else n_pass++;
    accept();
  endtask

  task automatic test_random();
    int lat;
    logic [31:0] ins;
    logic [109:0] exp;
    for (int n = 0; n < 25; n++) begin
      for (int w = $urandom_range(0, 3); w > 0; w--) begin
        wb_write(5'($urandom), $urandom);
      end
      ins = rand_instr();
      exp = exp_out(ins);
      send(ins, lat);
      n_checks++;
      if (lat !== 2 || w_obs !== exp)
        $display("FAIL rand_decode: instr=%h lat=%0d got %h expected %h", ins, lat, w_obs, exp);
      else n_pass++;
      repeat ($urandom_range(0, 2)) tick();
      n_checks++;
      if (w_obs !== exp || stage_out !== 1'b1)
        $display("FAIL rand_hold: instr=%h got %h expected %h", ins, w_obs, exp);
      else n_pass++;
      accept();
      n_checks++;
      if (stage_out !== 1'b0) $display("FAIL rand_release: got %b expected 0", stage_out);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins;
    logic [109:0] exp;
    alu_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      ins = rand_instr();
      exp = exp_out(ins);
      stage_in = 1'b1; instr_in = ins;
      tick();
      stage_in = 1'b0;
      tick();
      n_checks++;
      if (stage_out !== 1'b1 || w_obs !== exp)
        $display("FAIL b2b_decode: instr=%h so=%b got %h expected %h", ins, stage_out, w_obs, exp);
      else n_pass++;
      tick();
      n_checks++;
      if ({stage_out, in_ready} !== 2'b01)
        $display("FAIL b2b_ready: got %b expected 01", {stage_out, in_ready});
      else n_pass++;
    end
    alu_ready = 1'b0;
  endtask

  task automatic test_reset_hold();
    int lat;
    int seen;
    send(32'h0109_5020, lat);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    model_clear();
    n_checks++;
    if ({stage_out, in_ready, err_ovr} !== 3'b010 || w_obs !== '0)
      $display("FAIL reset_in_hold: got flags=%b obs=%h expected 010 and 0",
               {stage_out, in_ready, err_ovr}, w_obs);
    else n_pass++;
    stage_in = 1'b1; instr_in = 32'h0109_5020;
    tick();
    stage_in = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (stage_out === 1'b1) seen++;
      tick();
    end
    n_checks++;
    if (seen !== 0) $display("FAIL reset_in_decode: got %0d token cycles expected 0", seen);
    else n_pass++;
    send(32'h8D0B_FFFC, lat);
    n_checks++;
    if (lat !== 2 || w_obs !== exp_out(32'h8D0B_FFFC))
      $display("FAIL post_reset_decode: lat=%0d got %h expected %h", lat, w_obs, exp_out(32'h8D0B_FFFC));
    else n_pass++;
    accept();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_add();
    test_lw_hold();
    test_illegal_ovr();
    test_forward();
    test_random();
    test_back_to_back();
    test_reset_hold();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
